// File: rtl/dmem_pkg.sv
// dmem_pkg: shared line geometry and FSM state type for the dcache memory responder
package dmem_pkg;
  localparam int LINE_W = 256;
  localparam int OFFSET_W = 5;
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: line storage with synchronous write and index-addressed combinational read
//   clk_i   clock
//   we_i    write strobe for line idx_i
//   idx_i   line index (shared by read and write)
//   wdata_i line write data
//   rdata_o line read data
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LINES = 512,
  parameter int IDX_W = $clog2(DEPTH_LINES)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);
  logic [LINE_W-1:0] mem [DEPTH_LINES];
  always_ff @(posedge clk_i)
    if (we_i) mem[idx_i] <= wdata_i;
  assign rdata_o = mem[idx_i];
endmodule

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: fixed-latency single-outstanding line memory for the data cache
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset (storage is kept)
//   enable_i  request valid, accepted only in IDLE
//   write_i   1 = line write, 0 = line read
//   addr_i    byte address; line index is addr_i[log2(DEPTH_LINES)+4:5]
//   data_i    write line data
//   ack_o     one-cycle completion pulse, LATENCY cycles after acceptance
//   data_o    last completed read line, held across writes
//   err_o     only with DMEM_ALIGN_CHECK_EN: misaligned address flag during ack
module dcache_mem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DEPTH_LINES = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic              err_o,
`endif
  output logic [LINE_W-1:0] data_o
);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  state_t state, state_nxt;
  logic [7:0] cnt;
  logic cap_write;
  logic [IDX_W-1:0] cap_idx;
  logic [LINE_W-1:0] cap_data, rdata;
  logic done, we;
  logic unused_addr;
`ifdef DMEM_ALIGN_CHECK_EN
  logic [OFFSET_W-1:0] cap_off;
  assign unused_addr = ^addr_i[31:IDX_W+5];
`else
  assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[OFFSET_W-1:0]};
`endif
  // cnt reads k at the k-th edge after acceptance, so done marks the edge entering ACK
  assign done = state == BUSY && cnt == 8'(LATENCY);
  assign we = done && cap_write && !rst_i;
  dmem_line_array #(.DEPTH_LINES(DEPTH_LINES)) u_lines (
    .clk_i  (clk_i),
    .we_i   (we),
    .idx_i  (cap_idx),
    .wdata_i(cap_data),
    .rdata_o(rdata)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      data_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= state == IDLE ? 8'd1 : cnt + 8'd1;
      if (state == IDLE && enable_i) begin
        cap_write <= write_i;
        cap_idx   <= addr_i[IDX_W+4:5];
        cap_data  <= data_i;
`ifdef DMEM_ALIGN_CHECK_EN
        cap_off   <= addr_i[OFFSET_W-1:0];
`endif
      end
      if (done && !cap_write) data_o <= rdata;
    end
  always_comb
    state_nxt = state == IDLE ? (enable_i ? BUSY : IDLE) :
                state == BUSY ? (done ? ACK : BUSY) : IDLE;
  always_comb begin
    ack_o = state == ACK;
`ifdef DMEM_ALIGN_CHECK_EN
    err_o = state == ACK && |cap_off;
`endif
  end
endmodule
